// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that walks one full-adder cell across
// WIDTH operand bits, LSB first. Operands arrive through a valid/ready input
// handshake and the result leaves through a valid/ready output handshake.
// The sum and carry-out are registered and change only when an operation
// completes.

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_accept;
    logic             w_deliver;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shifted;

    // The single adder cell always looks at the operand LSBs and the carry flop.
    FullAdder u_full_adder (
        .a_i    (r_a[0]),
        .b_i    (r_b[0]),
        .cin_i  (r_carry),
        .sum_o  (w_fa_sum),
        .cout_o (w_fa_cout)
    );

    assign w_accept      = in_valid_i & w_in_ready;
    assign w_deliver     = out_ready_i & w_out_valid;
    assign w_last        = (r_cnt == LAST_CNT);
    assign w_sum_shifted = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept -> run WIDTH bits -> hold result until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_deliver) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake and status flags are pure decodes of the state register.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready  = 1'b1;
            ST_RUN:  w_busy      = 1'b1;
            ST_DONE: w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, and
    // capture the result on the final RUN edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a_i;
                        r_b      <= b_i;
                        r_carry  <= cin_i;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= w_sum_shifted;
                    r_carry  <= w_fa_cout;
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= w_sum_shifted;
                        r_cout <= w_fa_cout;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign busy_o      = w_busy;
    assign sum_o       = r_sum;
    assign cout_o      = r_cout;

endmodule

// One-bit full adder cell used by the serial adder.
module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
